pcm_sample_fifo: RTL
====================

// Module: pcm_sample_fifo
// PURPOSE
//  Elastic sample buffer between flash playback reads and the AC97 headphone path.
//  Accepts 16-bit flash words (sample in [15:8]); pops one 8-bit PCM sample per rising edge of AC97 ready.
//  Primes before playback, inserts silence on underrun and drains cleanly at end of track sequence.
//  Read-side pacing is removed from the flash/track sequencer: it refills while want_more is high.
// PARAMETERS
//  DEPTH_LOG2   4   FIFO depth = 2**DEPTH_LOG2 samples
//  PRIME_LEVEL  8   level required before PRIME->PLAY (1..2**DEPTH_LOG2)
//  LOW_WATER    6   want_more asserted while level < LOW_WATER
// PORTS
//  clock          in   1   27 MHz system clock
//  reset_b        in   1   asynchronous, active-low reset
//  flush          in   1   sync clear: empty FIFO, state->IDLE, counters kept
//  wr_valid       in   1   wr_data holds a valid flash word this cycle
//  wr_data        in   16  flash word; sample = wr_data[15:8]
//  wr_ready       out  1   ~full
//  drain          in   1   level: no more writes coming for this sequence
//  ready          in   1   AC97 frame strobe (level, synchronous to clock)
//  to_ac97_data   out  8   PCM sample to headphone
//  want_more      out  1   level < LOW_WATER and state != IDLE-with-drain
//  playing        out  1   state == PLAY
//  underrun       out  1   one-cycle pulse on a silent pop in PLAY
//  overflow       out  1   sticky: write attempted while full; cleared by flush
//  level          out  DEPTH_LOG2+1  current occupancy
//  underrun_count out  16  saturating count of underrun pulses; reset only
// BEHAVIOUR
//  Reset (reset_b=0, async): FIFO empty, state IDLE, to_ac97_data=8'h00, wr_ready=1, want_more=0,
//   playing=0, underrun=0, overflow=0, level=0, underrun_count=0, last_ready=0.
//  pop_evt = ready & ~last_ready (last_ready registered every cycle).
//  Write: wr_valid & ~full -> store wr_data[15:8]; level +1 next cycle. wr_valid & full -> dropped, overflow<=1.
//  Simultaneous push+pop: both happen, level unchanged. A word written in cycle N is poppable from N+1.
//  States:
//   IDLE : output 00. First accepted write -> PRIME. want_more=1 unless drain.
//   PRIME: pop_evt outputs 00, no pop, no underrun. level>=PRIME_LEVEL, or drain & level>0 -> PLAY.
//   PLAY : pop_evt & ~empty -> to_ac97_data<=head sample (visible the cycle after the edge), pop.
//          pop_evt & empty & ~drain -> to_ac97_data<=00, underrun pulse, count+1 (saturate FFFF), ->PRIME.
//          pop_evt & empty & drain -> to_ac97_data<=00, no underrun, ->IDLE.
//  to_ac97_data holds its value between pop_evts.
//  flush wins over every event in the same cycle: pointers=0, state IDLE, to_ac97_data=00, overflow=0.
//  Reset mid-playback: immediate return to reset values; no partial sample is emitted.
//  Pointers: DEPTH_LOG2+1 bits with wrap bit; full = MSBs differ & LSBs equal; empty = pointers equal.
//  level = wr_ptr - rd_ptr (modulo 2**(DEPTH_LOG2+1)).
// STRUCTURE
//  Shared package audio_pkg: state encodings (IDLE=0, PRIME=1, PLAY=2), SILENCE_SAMPLE=8'h00.
//  Sub-module sample_ram: 2**DEPTH_LOG2 x 8 register array, 1 write port, combinational read port.
//  Top holds pointers, edge detect, FSM and counters.
// TESTING
//  1 Reset, push 8 words 0x1100..0x8800, 8 ready edges -> PLAY after 8th write; outputs 11,22..88 in order.
//  2 PLAY with empty FIFO, drain=0, one ready edge -> to_ac97_data=00, underrun 1-cycle pulse, count=1,
//    state PRIME.
//  3 Push 17 words with DEPTH_LOG2=4, no pops -> level=16, wr_ready=0, 17th dropped, overflow=1.
//  4 Push 3 words, assert drain -> PLAY; 4 edges -> outputs 3 samples then 00, state IDLE, no underrun.
//  5 Full FIFO, push + ready edge same cycle -> level stays 16, head popped, new word stored.
//  6 Flush during PLAY with concurrent write and ready edge -> level=0, IDLE, output 00, overflow=0.
//  7 reset_b low mid-PLAY between clock edges -> outputs reset immediately, before next clock.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types: playback FSM encoding, silence value and a saturating counter helper.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } play_state_t;

    localparam logic [7:0] SILENCE_SAMPLE = 8'h00;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Sample storage: 2**ADDR_W x 8 register array, one write port, combinational read port.
module sample_ram #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pcm_sample_fifo.sv
// Elastic PCM sample buffer between flash playback reads and the AC97 headphone path:
// primes before playback, emits silence on underrun, drains to IDLE at end of sequence.
module pcm_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int PRIME_LEVEL = 8,
    parameter int LOW_WATER   = 6
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [15:0]           wr_data,
    output logic                  wr_ready,
    input  logic                  drain,
    input  logic                  ready,
    output logic [7:0]            to_ac97_data,
    output logic                  want_more,
    output logic                  playing,
    output logic                  underrun,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underrun_count
);

    localparam int AW = DEPTH_LOG2;
    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WATER);

    play_state_t    r_state, w_state_nxt;
    logic [LW-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt, w_level, w_level_nxt;
    logic           r_last_ready, r_underrun, r_overflow, r_want_more;
    logic [7:0]     r_data, w_data_nxt, w_head;
    logic [15:0]    r_ucount;
    logic           w_full, w_empty, w_pop_evt;
    logic           w_push, w_pop, w_data_ld, w_underrun_nxt, w_overflow_set;

    sample_ram #(.ADDR_W(AW)) u_ram (
        .clock   (clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (wr_data[15:8]),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_pop_evt = ready && !r_last_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_push         = 1'b0;
        w_data_ld      = 1'b0;
        w_data_nxt     = SILENCE_SAMPLE;
        w_underrun_nxt = 1'b0;
        w_overflow_set = 1'b0;
        case (r_state)
            ST_IDLE: w_data_ld = w_pop_evt;
            ST_PRIME: begin
                w_data_ld = w_pop_evt;
                if (w_level >= PRIME_LVL || (drain && !w_empty)) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_pop_evt) begin
                    w_data_ld = 1'b1;
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_data_nxt = w_head;
                    end else if (drain) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_underrun_nxt = 1'b1;
                        w_state_nxt    = ST_PRIME;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
        w_push         = wr_valid && (!w_full || w_pop);
        w_overflow_set = wr_valid && !w_push;
        if (r_state == ST_IDLE && w_push) w_state_nxt = ST_PRIME;
        if (flush) begin
            w_state_nxt    = ST_IDLE;
            w_pop          = 1'b0;
            w_push         = 1'b0;
            w_data_ld      = 1'b1;
            w_data_nxt     = SILENCE_SAMPLE;
            w_underrun_nxt = 1'b0;
            w_overflow_set = 1'b0;
        end
    end

    assign w_wr_ptr_nxt = flush ? '0 : r_wr_ptr + LW'(w_push);
    assign w_rd_ptr_nxt = flush ? '0 : r_rd_ptr + LW'(w_pop);
    assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_ready <= 1'b0;
            r_data       <= SILENCE_SAMPLE;
            r_underrun   <= 1'b0;
            r_overflow   <= 1'b0;
            r_ucount     <= '0;
            r_want_more  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_last_ready <= ready;
            r_underrun   <= w_underrun_nxt;
            if (w_data_ld) r_data <= w_data_nxt;
            if (flush) r_overflow <= 1'b0;
            else if (w_overflow_set) r_overflow <= 1'b1;
            if (w_underrun_nxt) r_ucount <= sat_inc16(r_ucount);
            r_want_more  <= (w_level_nxt < LOW_LVL) && !(w_state_nxt == ST_IDLE && drain);
        end
    end

    assign wr_ready       = !w_full;
    assign to_ac97_data   = r_data;
    assign want_more      = r_want_more;
    assign playing        = (r_state == ST_PLAY);
    assign underrun       = r_underrun;
    assign overflow       = r_overflow;
    assign level          = w_level;
    assign underrun_count = r_ucount;

endmodule
